mips_mem_bridge: RTL

- Sits between the multicycle MIPS datapath's single shared memory port and an external word-wide request/acknowledge memory bus. The datapath port is the IorD-selected address plus the MemWrite/read strobes.
- Turns level-held datapath strobes into exactly one bus transaction per access and tolerates variable-latency memory.
- Stalls the datapath while an access is outstanding and flags misaligned or timed-out accesses.

---
 rtl/mips_mem_bridge_if.sv | 27 ++
 rtl/mips_mem_bridge.sv | 136 +++++++++++++
 2 files changed

// File: rtl/mips_mem_bridge_if.sv
// Word-wide request/acknowledge memory bus between the bridge (master) and memory (slave).
interface mips_mem_bridge_if;
  logic        bus_req;
  logic        bus_we;
  logic [29:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req,
    output bus_we,
    output bus_addr,
    output bus_wdata,
    input  bus_ack,
    input  bus_rdata
  );

  modport slave (
    input  bus_req,
    input  bus_we,
    input  bus_addr,
    input  bus_wdata,
    output bus_ack,
    output bus_rdata
  );
endinterface

// File: rtl/mips_mem_bridge.sv
// Bridges the multicycle MIPS shared memory port onto a req/ack bus: one transaction per
// held access, datapath stall while outstanding, sticky error on misalignment or timeout.
module mips_mem_bridge #(
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'h0000_0000
) (
  input  logic                     cclk,
  input  logic                     rstb,
  input  logic [31:0]              Adr,
  input  logic [31:0]              WriteData,
  input  logic                     MemRead,
  input  logic                     MemWrite,
  input  logic                     err_clr,
  output logic                     Stall,
  output logic [31:0]              ReadData,
  output logic                     BusErr,
  mips_mem_bridge_if.master        bus
);

  typedef enum logic [1:0] {StIdle, StBus, StDone} state_e;

  localparam logic [15:0] CntLimit = 16'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [29:0] addr_q, addr_d;
  logic [1:0]  lo_q, lo_d;
  logic        we_q, we_d;
  logic [31:0] wdata_q, wdata_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        served_q, served_d;
  logic [31:0] srv_adr_q, srv_adr_d;
  logic        srv_we_q, srv_we_d;

  logic has_req, same_acc, req_go, err_set;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    lo_d      = lo_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    srv_adr_d = srv_adr_q;
    srv_we_d  = srv_we_q;
    err_set   = 1'b0;
    Stall     = 1'b0;

    has_req  = MemRead | MemWrite;
    same_acc = (Adr == srv_adr_q) && (MemWrite == srv_we_q);
    // A level-held strobe for an access already served must not re-issue it.
    req_go   = has_req && !(served_q && same_acc);
    served_d = served_q && has_req && same_acc;

    case (state_q)
      StIdle: begin
        if (req_go) begin
          Stall   = 1'b1;
          addr_d  = Adr[31:2];
          lo_d    = Adr[1:0];
          we_d    = MemWrite;
          wdata_d = WriteData;
          cnt_d   = '0;
          if (Adr[1:0] != 2'b00) begin
            err_set = 1'b1;
            if (!MemWrite) rdata_d = ERR_DATA;
            state_d = StDone;
          end else begin
            state_d = StBus;
          end
        end
      end
      StBus: begin
        Stall = 1'b1;
        if (bus.bus_ack) begin
          if (!we_q) rdata_d = bus.bus_rdata;
          state_d = StDone;
        end else if (cnt_q == CntLimit) begin
          err_set = 1'b1;
          if (!we_q) rdata_d = ERR_DATA;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StDone: begin
        served_d  = 1'b1;
        srv_adr_d = {addr_q, lo_q};
        srv_we_d  = we_q;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase

    err_d = err_clr ? 1'b0 : err_q;
    if (err_set) err_d = 1'b1;
  end

  always_ff @(posedge cclk or negedge rstb) begin
    if (!rstb) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      lo_q      <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      cnt_q     <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      served_q  <= 1'b0;
      srv_adr_q <= '0;
      srv_we_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      lo_q      <= lo_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      cnt_q     <= cnt_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      served_q  <= served_d;
      srv_adr_q <= srv_adr_d;
      srv_we_q  <= srv_we_d;
    end
  end

  assign ReadData      = rdata_q;
  assign BusErr        = err_q;
  assign bus.bus_req   = (state_q == StBus);
  assign bus.bus_we    = we_q;
  assign bus.bus_addr  = addr_q;
  assign bus.bus_wdata = wdata_q;

endmodule
